// File: rtl/pos_remote_rx_buffer_if.sv
// Link-side and ring-side signals of the remote receive buffer.
// slave = buffer's view, master = the surrounding logic (or bench).
interface pos_remote_rx_buffer_if #(
  parameter int PKT_W    = 24,
  parameter int GCID_W   = 12,
  parameter int LT_ALL_W = 8,
  parameter int LT_W     = 4
);
  // inter-FPGA link side
  logic [PKT_W-1:0]    net_offset_pkt;
  logic [GCID_W-1:0]   net_gcid;
  logic [LT_ALL_W-1:0] net_lifetime;
  logic                net_valid;
  logic                net_ready;
  // position input ring side
  logic [PKT_W-1:0]    remote_offset_pkt;
  logic [GCID_W-1:0]   remote_gcid;
  logic [LT_W-1:0]     remote_lifetime;
  logic                remote_valid;
  logic                remote_ack;
  // status
  logic                remote_buffer_back_pressure;
  logic                buffer_empty;
  logic [15:0]         drop_count;

  modport slave (
    input  net_offset_pkt, net_gcid, net_lifetime, net_valid, remote_ack,
    output net_ready, remote_offset_pkt, remote_gcid, remote_lifetime,
           remote_valid, remote_buffer_back_pressure, buffer_empty, drop_count
  );

  modport master (
    output net_offset_pkt, net_gcid, net_lifetime, net_valid, remote_ack,
    input  net_ready, remote_offset_pkt, remote_gcid, remote_lifetime,
           remote_valid, remote_buffer_back_pressure, buffer_empty, drop_count
  );
endinterface

// File: rtl/pos_remote_rx_buffer.sv
// Receive-side terminator for remote position offset packets.
// Packets whose lifetime slot for this FPGA is zero are dropped and counted;
// the rest are queued in a FIFO and presented through a one-entry output
// register with a valid/ack handshake. Almost-full drives network back pressure.
module pos_remote_rx_buffer #(
  parameter int DEPTH                   = 16,
  parameter int AF_MARGIN               = 4,
  parameter int LIFETIME_SLOT           = 0,
  parameter int OFFSET_PKT_STRUCT_WIDTH = 24,
  parameter int GLOBAL_CELL_ID_WIDTH    = 4,
  parameter int NUM_REMOTE_DEST_NODES   = 2,
  parameter int NB_CELL_COUNT_WIDTH     = 4
) (
  input logic clk,
  input logic rst,
  pos_remote_rx_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = OFFSET_PKT_STRUCT_WIDTH;
  localparam int GW = 3 * GLOBAL_CELL_ID_WIDTH;
  localparam int LW = NB_CELL_COUNT_WIDTH;
  localparam int EW = PW + GW + LW;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW+1:0] AF_TH   = (AW + 2)'(DEPTH - AF_MARGIN);

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  out_state_t    state;

  logic [LW-1:0] sel_lifetime;
  logic          accept;
  logic          push;
  logic          pop;
  logic          full_next;
  logic [AW+1:0] occ_next;

  logic [PW-1:0] out_pkt;
  logic [GW-1:0] out_gcid;
  logic [LW-1:0] out_lifetime;
  logic          back_pressure;
  logic          empty;
  logic [15:0]   drop_count;

  assign sel_lifetime = bus.net_lifetime[LIFETIME_SLOT*LW +: LW];

  // Ready depends only on the registered count: a full FIFO refuses a push
  // even in a cycle where it also pops.
  assign bus.net_ready = (count < DEPTH_C);
  assign accept        = bus.net_valid && bus.net_ready;
  assign push          = accept && (sel_lifetime != '0);

  // The output register pulls from the FIFO whenever it is empty, or when
  // its current head is acked (back-to-back delivery without a bubble).
  assign pop = (count != '0) && ((state == OUT_EMPTY) || bus.remote_ack);

  assign count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);

  // Output register occupancy after this edge
  always_comb begin
    full_next = (state == OUT_FULL);
    if (pop)
      full_next = 1'b1;
    else if ((state == OUT_FULL) && bus.remote_ack)
      full_next = 1'b0;
  end

  assign occ_next = (AW + 2)'(count_next) + (AW + 2)'(full_next);

  // FIFO storage write port (no reset so it can map onto RAM)
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {bus.net_offset_pkt, bus.net_gcid, sel_lifetime};
  end

  // FIFO pointers and count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Output register FSM: holds the head packet stable until acked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= OUT_EMPTY;
      out_pkt      <= '0;
      out_gcid     <= '0;
      out_lifetime <= '0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (pop) begin
            {out_pkt, out_gcid, out_lifetime} <= mem[rd_ptr];
            state <= OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (bus.remote_ack) begin
            if (pop)
              {out_pkt, out_gcid, out_lifetime} <= mem[rd_ptr];
            else
              state <= OUT_EMPTY;
          end
        end
        default: state <= OUT_EMPTY;
      endcase
    end
  end

  // Status flags from next-state occupancy, plus saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      back_pressure <= 1'b0;
      empty         <= 1'b1;
      drop_count    <= '0;
    end else begin
      back_pressure <= (occ_next >= AF_TH);
      empty         <= (occ_next == '0);
      if (accept && (sel_lifetime == '0) && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end

  assign bus.remote_valid                = (state == OUT_FULL);
  assign bus.remote_offset_pkt           = out_pkt;
  assign bus.remote_gcid                 = out_gcid;
  assign bus.remote_lifetime             = out_lifetime;
  assign bus.remote_buffer_back_pressure = back_pressure;
  assign bus.buffer_empty                = empty;
  assign bus.drop_count                  = drop_count;
endmodule
